// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with a small first-word-fall-through byte FIFO.
// Samples UART_IN through a 2-flop synchroniser, checks 1..15 stop bits and
// exposes sticky FRAME_ERR / OVERRUN flags plus a registered RX_INT.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       UART_CLK,
    input  logic       RESET,
    input  logic       UART_IN,
    input  logic [3:0] STOP_BITS,
    input  logic       RD_EN,
    input  logic       ERR_CLR,
`ifdef UART_RX_PARITY_EN
    input  logic       PAR_ODD,
    output logic       PAR_ERR,
`endif
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       RX_FULL,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       RX_INT
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] MID_START = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] MID_BIT   = TW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd5,
`endif
        WAIT_IDLE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    bit_q, bit_d;          // data bit index, then stop samples taken
    logic [3:0]    stop_cnt_q, stop_cnt_d;
    logic          stop_bad_q, stop_bad_d;
    logic          par_bad_q, par_bad_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          par_err_q, par_err_d;
    logic          rx_int_q, rx_int_d;
    logic          rx_s, mid, push, frame_set, par_set;
    logic          full, pop_ok, push_ok, overrun_set;

    assign rx_s = sync_q[1];
    assign mid  = (state_q == START) ? (timer_q == MID_START) : (timer_q == MID_BIT);

    // Receive FSM: bit timing, shifting and stop/parity evaluation
    always_comb begin
        sync_d     = {sync_q[0], UART_IN};
        state_d    = state_q;
        timer_d    = timer_q + TW'(1);
        bit_d      = bit_q;
        stop_cnt_d = stop_cnt_q;
        stop_bad_d = stop_bad_q;
        par_bad_d  = par_bad_q;
        shift_d    = shift_q;
        push       = 1'b0;
        frame_set  = 1'b0;
        par_set    = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!rx_s) state_d = START;
            end
            START: if (mid) begin
                timer_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d    = DATA;
                    bit_d      = 4'd0;
                    stop_cnt_d = (STOP_BITS == 4'd0) ? 4'd1 : STOP_BITS;
                    stop_bad_d = 1'b0;
                    par_bad_d  = 1'b0;
                end
            end
            DATA: if (mid) begin
                timer_d = '0;
                shift_d = {rx_s, shift_q[7:1]};
                if (bit_q == 4'd7) begin
                    bit_d = 4'd0;
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (mid) begin
                timer_d = '0;
                state_d = STOP;
                if (rx_s != (^shift_q ^ PAR_ODD)) begin
                    par_set   = 1'b1;
                    par_bad_d = 1'b1;
                end
            end
`endif
            STOP: if (mid) begin
                timer_d = '0;
                bit_d   = bit_q + 4'd1;
                if (bit_q + 4'd1 == stop_cnt_q) begin
                    if (stop_bad_q || !rx_s) begin
                        frame_set = 1'b1;
                        state_d   = rx_s ? IDLE : WAIT_IDLE;
                    end else begin
                        push    = !par_bad_q;
                        state_d = IDLE;
                    end
                end else if (!rx_s) begin
                    stop_bad_d = 1'b1;
                end
            end
            WAIT_IDLE: begin
                // a held-low line (break) must not be taken as a new start bit
                timer_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointers, storage and sticky flags
    always_comb begin
        full        = (count_q == DEPTH_C);
        pop_ok      = RD_EN && (count_q != '0);
        push_ok     = push && (!full || pop_ok);
        overrun_set = push && full && !pop_ok;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
        frame_err_d = frame_set   | (frame_err_q & ~ERR_CLR);
        overrun_d   = overrun_set | (overrun_q & ~ERR_CLR);
        par_err_d   = par_set     | (par_err_q & ~ERR_CLR);
`ifdef UART_RX_PARITY_EN
        rx_int_d = (count_d != '0) | frame_err_d | overrun_d | par_err_d;
`else
        rx_int_d = (count_d != '0) | frame_err_d | overrun_d;
`endif
    end

    // State registers; synchroniser presets high so reset never fakes a start
    always_ff @(posedge UART_CLK or posedge RESET) begin
        if (RESET) begin
            sync_q      <= 2'b11;
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_q       <= '0;
            stop_cnt_q  <= 4'd1;
            stop_bad_q  <= 1'b0;
            par_bad_q   <= 1'b0;
            shift_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            par_err_q   <= 1'b0;
            rx_int_q    <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_q       <= bit_d;
            stop_cnt_q  <= stop_cnt_d;
            stop_bad_q  <= stop_bad_d;
            par_bad_q   <= par_bad_d;
            shift_q     <= shift_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            par_err_q   <= par_err_d;
            rx_int_q    <= rx_int_d;
        end
    end

    assign RX_DATA   = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign RX_VALID  = (count_q != '0);
    assign RX_FULL   = full;
    assign FRAME_ERR = frame_err_q;
    assign OVERRUN   = overrun_q;
    assign RX_INT    = rx_int_q;
`ifdef UART_RX_PARITY_EN
    assign PAR_ERR   = par_err_q;
`else
    logic unused_par;
    assign unused_par = par_err_q | par_bad_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (CLKS_PER_BIT=16, FIFO_DEPTH=4, no parity).
module tb_uart_rx_fifo;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_in = 1'b1;
    logic [3:0] stop_bits = 4'd1;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_full, frame_err, overrun, rx_int;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int lat;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .UART_CLK(clk), .RESET(rst), .UART_IN(uart_in), .STOP_BITS(stop_bits),
        .RD_EN(rd_en), .ERR_CLR(err_clr), .RX_DATA(rx_data), .RX_VALID(rx_valid),
        .RX_FULL(rx_full), .FRAME_ERR(frame_err), .OVERRUN(overrun), .RX_INT(rx_int)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One frame, starting at a negedge; stop_vals[i] is the level of stop bit i
    task automatic send_frame(input logic [7:0] d, input int nstop, input logic [3:0] stop_vals);
        start_cyc = cyc;
        uart_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_in = d[i];
            repeat (CPB) @(negedge clk);
        end
        for (int i = 0; i < nstop; i++) begin
            uart_in = stop_vals[i];
            repeat (CPB) @(negedge clk);
        end
        uart_in = 1'b1;
    endtask

    // Sends a good 1-stop frame and measures cycles from falling edge to RX_VALID
    task automatic send_timed(input logic [7:0] d, output int l);
        l = -1;
        fork
            send_frame(d, 1, 4'b0001);
            begin
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (rx_valid) begin
                        l = cyc - start_cyc;
                        break;
                    end
                end
            end
        join
    endtask

    task automatic pop;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_valid", rx_valid, 1'b0);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_int", {rx_full, frame_err, overrun, rx_int}, 4'b0000);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // basic receive and latency
        send_timed(8'hA5, lat);
        chk("basic_latency", lat, 155);
        chk("basic_data", rx_data, 8'hA5);
        chk("basic_int", rx_int, 1'b1);
        repeat (20) @(negedge clk);
        pop;
        chk("basic_pop_valid", rx_valid, 1'b0);
        chk("basic_pop_data", rx_data, 8'h00);
        chk("basic_pop_int", rx_int, 1'b0);

        // STOP_BITS=0 behaves as one stop bit
        stop_bits = 4'd0;
        send_timed(8'h5A, lat);
        chk("stop0_latency", lat, 155);
        chk("stop0_data", rx_data, 8'h5A);
        repeat (20) @(negedge clk);
        pop;

        // glitch rejection
        uart_in = 1'b0;
        repeat (6) @(negedge clk);
        uart_in = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_flags", {rx_valid, frame_err, overrun, rx_int}, 4'b0000);

        // two stop bits, second one low
        stop_bits = 4'd2;
        send_frame(8'h3C, 2, 4'b0001);
        repeat (20) @(negedge clk);
        chk("frame_err", frame_err, 1'b1);
        chk("frame_fifo_empty", rx_valid, 1'b0);
        chk("frame_int", rx_int, 1'b1);
        pulse_clr;
        chk("frame_clr", {frame_err, rx_int}, 2'b00);

        // overrun: five bytes, no reads
        stop_bits = 4'd1;
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1, 4'b0001);
        repeat (10) @(negedge clk);
        chk("ovr_full", rx_full, 1'b1);
        chk("ovr_flag", overrun, 1'b1);
        for (int b = 1; b <= 4; b++) begin
            chk("ovr_read", rx_data, 32'(b));
            pop;
        end
        chk("ovr_empty", rx_valid, 1'b0);
        pulse_clr;
        chk("ovr_clr", {overrun, rx_int}, 2'b00);

        // full boundary: pop coincides with push of 0x55
        for (int b = 1; b <= 4; b++) send_frame(8'(b), 1, 4'b0001);
        repeat (10) @(negedge clk);
        chk("bnd_full_before", rx_full, 1'b1);
        fork
            send_frame(8'h55, 1, 4'b0001);
            begin
                repeat (154) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        chk("bnd_overrun", overrun, 1'b0);
        chk("bnd_full", rx_full, 1'b1);
        chk("bnd_read0", rx_data, 8'h02); pop;
        chk("bnd_read1", rx_data, 8'h03); pop;
        chk("bnd_read2", rx_data, 8'h04); pop;
        chk("bnd_read3", rx_data, 8'h55); pop;
        chk("bnd_empty", rx_valid, 1'b0);

        // reset mid-frame with a byte already queued
        send_frame(8'h66, 1, 4'b0001);
        repeat (10) @(negedge clk);
        chk("rst_pre_valid", rx_valid, 1'b1);
        fork
            send_frame(8'hFF, 1, 4'b0001);
            begin
                repeat (CPB * 5) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                chk("rst_mid_outs", {rx_data, rx_valid, rx_full, frame_err, overrun, rx_int}, 13'h0);
                @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        chk("rst_after_frame", {rx_valid, frame_err, overrun, rx_int}, 4'b0000);
        send_timed(8'h81, lat);
        chk("rst_next_latency", lat, 155);
        chk("rst_next_data", rx_data, 8'h81);
        repeat (20) @(negedge clk);
        chk("rst_next_flags", {frame_err, overrun}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
